// File: rtl/ldm_sequencer.sv
// Load-multiple sequencer: one word load per mask bit in ascending register order,
// then an optional base-register writeback. One memory request outstanding at a time.
module ldm_sequencer #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] base,
    input  logic [3:0]    ra,
    input  logic [15:0]   reg_mask,
    input  logic          wback,
    input  logic          dec,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          rf_we,
    output logic [3:0]    rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          pc_load
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   mask_q, mask_d;
    logic [3:0]    ra_q, ra_d;
    logic          wb_q, wb_d;
    logic          zero_q, zero_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] final_q, final_d;

    logic [4:0]    cnt;
    logic [DW-1:0] span;
    logic [3:0]    tgt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 16; i++) cnt = cnt + 5'(reg_mask[i]);
        span = DW'({cnt, 2'b00});
    end

    // Lowest remaining set bit is the next load target.
    always_comb begin
        tgt = '0;
        for (int i = 15; i >= 0; i--) if (mask_q[i]) tgt = 4'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            ra_q    <= '0;
            wb_q    <= 1'b0;
            zero_q  <= 1'b0;
            addr_q  <= '0;
            final_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ra_q    <= ra_d;
            wb_q    <= wb_d;
            zero_q  <= zero_d;
            addr_q  <= addr_d;
            final_q <= final_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        ra_d     = ra_q;
        wb_d     = wb_q;
        zero_d   = zero_q;
        addr_d   = addr_q;
        final_d  = final_q;
        done     = 1'b0;
        err      = 1'b0;
        mem_req  = 1'b0;
        mem_addr = '0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        pc_load  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (reg_mask != 16'h0) begin
                        mask_d  = reg_mask;
                        ra_d    = ra;
                        // A base register that is also loaded keeps the loaded value.
                        wb_d    = wback & ~reg_mask[ra];
                        zero_d  = 1'b0;
                        addr_d  = dec ? AW'(base) - AW'(span) : AW'(base);
                        final_d = dec ? base - span : base + span;
                        state_d = S_ISSUE;
                    end else begin
                        zero_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                mem_req  = 1'b1;
                mem_addr = {addr_q[AW-1:2], 2'b00};
                if (mem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    rf_we    = 1'b1;
                    rf_waddr = tgt;
                    rf_wdata = mem_rdata;
                    pc_load  = (tgt == 4'd15);
                    mask_d   = mask_q & (mask_q - 16'd1);
                    addr_d   = addr_q + AW'(4);
                    if (mask_d != 16'h0) state_d = S_ISSUE;
                    else if (wb_q)       state_d = S_WB;
                    else                 state_d = S_DONE;
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = ra_q;
                rf_wdata = final_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                err     = zero_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_ldm_sequencer.sv
// Scoreboard bench for ldm_sequencer: expected addresses and register writes are
// queued when an operation is launched and consumed as the DUT produces them.
module tb_ldm_sequencer;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] K = 32'hA5A5A5A5;

    logic          clk = 1'b0;
    logic          rst, start, wback, dec;
    logic [DW-1:0] base;
    logic [3:0]    ra;
    logic [15:0]   reg_mask;
    logic          busy, done, err, mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt, mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          rf_we;
    logic [3:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          pc_load;

    always #5 clk = ~clk;

    ldm_sequencer #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .ra(ra), .reg_mask(reg_mask),
        .wback(wback), .dec(dec), .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc_load(pc_load)
    );

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] dat;
        logic        pc;
    } wr_t;

    logic [31:0] q_addr[$];
    wr_t         q_wr[$];
    int checks = 0, errors = 0;
    int gnt_delay = 0, rv_delay = 0, grants = 0, dones = 0, we_cnt = 0, we_rv = 0;
    bit rearm = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Memory responder: gnt after gnt_delay request cycles, rvalid rv_delay cycles
    // after the cycle following gnt; data = address ^ K.
    initial begin
        bit pend;
        bit waiting;
        int gc;
        int rvc;
        logic [31:0] raddr;
        pend = 0; waiting = 0; gc = 0; rvc = 0; raddr = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (rearm) begin gc = gnt_delay; rearm = 0; end
            if (pend) begin
                if (rvc == 0) begin mem_rvalid = 1'b1; mem_rdata = raddr ^ K; pend = 0; end
                else begin rvc--; mem_rvalid = 1'b0; end
            end else mem_rvalid = 1'b0;
            mem_gnt = 1'b0;
            if (waiting && mem_req !== 1'b1) begin
                chk("req_hold", mem_req, 1);
                waiting = 0;
            end
            if (mem_req === 1'b1 && !pend) begin
                if (gc == 0) begin
                    mem_gnt = 1'b1; waiting = 0; grants++;
                    raddr = mem_addr; pend = 1; rvc = rv_delay; gc = gnt_delay;
                    if (q_addr.size() == 0) chk("addr_unexp", 1, 0);
                    else chk("mem_addr", mem_addr, q_addr.pop_front());
                end else begin
                    gc--; waiting = 1;
                    if (q_addr.size() != 0) chk("addr_stable", mem_addr, q_addr[0]);
                end
            end
        end
    end

    // Register-file write monitor.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                we_cnt++;
                if (mem_rvalid === 1'b1) we_rv++;
                if (q_wr.size() == 0) chk("rf_we_unexp", 1, 0);
                else begin
                    e = q_wr.pop_front();
                    chk("rf_waddr", rf_waddr, e.a);
                    chk("rf_wdata", rf_wdata, e.dat);
                    chk("pc_load", pc_load, e.pc);
                end
            end else if (pc_load === 1'b1) chk("pc_load_alone", pc_load, 0);
            if (done === 1'b1) dones++;
            if (err === 1'b1 && done !== 1'b1) chk("err_alone", err, 0);
        end
    end

    task automatic run_op(input logic [31:0] b, input logic [3:0] r, input logic [15:0] m,
                          input logic wb, input logic dn, input int gd, input int rd,
                          input bit spam);
        int n, exp_lat, edges, g0, we0, rv0, d0;
        bit wbw, seen;
        logic [31:0] a, fin;
        wr_t w;
        n = 0;
        for (int i = 0; i < 16; i++) n += int'(m[i]);
        a   = dn ? b - 32'(4 * n) : b;
        fin = dn ? b - 32'(4 * n) : b + 32'(4 * n);
        wbw = wb && !m[r] && (n != 0);
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                q_addr.push_back({a[31:2], 2'b00});
                w.a = 4'(i); w.dat = {a[31:2], 2'b00} ^ K; w.pc = (i == 15);
                q_wr.push_back(w);
                a = a + 32'd4;
            end
        end
        if (wbw) begin
            w.a = r; w.dat = fin; w.pc = 1'b0;
            q_wr.push_back(w);
        end
        // Edges after the start-sampling edge; the start cycle itself is cycle 1.
        exp_lat = (n == 0) ? 1 : 2 * n + 1 + int'(wbw) + n * (gd + rd);
        gnt_delay = gd; rv_delay = rd; rearm = 1;
        g0 = grants; we0 = we_cnt; rv0 = we_rv; d0 = dones;
        @(posedge clk); #1;
        base = b; ra = r; reg_mask = m; wback = wb; dec = dn; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1; seen = 0;
        while (edges < 300) begin
            @(negedge clk);
            if (edges == 1) chk("busy_after_start", busy, 1);
            if (done === 1'b1) begin seen = 1; break; end
            @(posedge clk); #1;
            edges++;
            if (spam && edges == 2) begin
                start = 1'b1; base = $urandom; reg_mask = 16'($urandom);
                ra = 4'($urandom); wback = 1'b1; dec = ~dn;
            end else start = 1'b0;
        end
        if (!seen) chk("timeout", 0, 1);
        chk("latency", 64'(edges), 64'(exp_lat));
        chk("err", err, (n == 0));
        if (spam) begin start = 1'b1; reg_mask = 16'hFFFF; end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_req", mem_req, 0);
        chk("grants", 64'(grants - g0), 64'(n));
        chk("we_rvalid", 64'(we_rv - rv0), 64'(n));
        chk("we_total", 64'(we_cnt - we0), 64'(n + int'(wbw)));
        chk("dones", 64'(dones - d0), 1);
        chk("wr_left", 64'(q_wr.size()), 0);
        chk("addr_left", 64'(q_addr.size()), 0);
        q_wr.delete(); q_addr.delete();
    endtask

    task automatic reset_mid_op();
        int g0, we0, d0;
        wr_t w;
        gnt_delay = 0; rv_delay = 3; rearm = 1;
        q_addr.push_back(32'h3000); q_addr.push_back(32'h3004);
        w.a = 4'd4; w.dat = 32'h3000 ^ K; w.pc = 1'b0;
        q_wr.push_back(w);
        g0 = grants; we0 = we_cnt; d0 = dones;
        @(posedge clk); #1;
        base = 32'h3000; ra = 4'd1; reg_mask = 16'h00F0; wback = 1'b1; dec = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (grants - g0 >= 2) break;
        end
        chk("rst_reach_2nd", 64'(grants - g0), 2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_done", done, 0);
        repeat (8) @(negedge clk);
        chk("rst_no_done", 64'(dones - d0), 0);
        chk("rst_writes", 64'(we_cnt - we0), 1);
        chk("rst_wr_left", 64'(q_wr.size()), 0);
        chk("rst_addr_left", 64'(q_addr.size()), 0);
        q_wr.delete(); q_addr.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; base = 32'h10; ra = '0; reg_mask = 16'h0001;
        wback = 1'b0; dec = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy0", busy, 0);
        chk("rst_done0", done, 0);
        chk("rst_err0", err, 0);
        chk("rst_req0", mem_req, 0);
        chk("rst_addr0", mem_addr, 0);
        chk("rst_we0", rf_we, 0);
        chk("rst_waddr0", rf_waddr, 0);
        chk("rst_wdata0", rf_wdata, 0);
        chk("rst_pc0", pc_load, 0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", busy, 0);

        run_op(32'h0000_1000, 4'd0,  16'h000E, 1'b1, 1'b0, 0, 0, 0);
        run_op(32'h0000_2000, 4'd13, 16'h8003, 1'b1, 1'b1, 0, 0, 0);
        run_op(32'h0000_4000, 4'd2,  16'h0006, 1'b1, 1'b0, 0, 0, 0);
        run_op(32'h0000_5000, 4'd3,  16'h0000, 1'b1, 1'b0, 0, 0, 0);
        run_op(32'h0000_6000, 4'd5,  16'h0010, 1'b0, 1'b0, 5, 3, 0);
        reset_mid_op();
        run_op(32'h0000_7000, 4'd0,  16'h00F0, 1'b1, 1'b1, 0, 0, 0);
        run_op(32'hFFFF_FFF8, 4'd1,  16'h000F, 1'b1, 1'b0, 0, 1, 0);
        run_op(32'h0000_0004, 4'd14, 16'h0003, 1'b1, 1'b1, 1, 0, 1);
        run_op(32'h0000_8000, 4'd3,  16'hFFFF, 1'b1, 1'b0, 0, 0, 1);
        for (int k = 0; k < 4; k++)
            run_op({$urandom, 2'b00} & 32'hFFFF_FFFC, 4'($urandom), 16'($urandom),
                   1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
